// File: rtl/hex_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// hex_scroll_ctrl
//   Lab-board controller that fills a small nibble buffer from the switches
//   and drives it onto the six hex displays, either as a right-justified
//   "load view" (newest entry on HEX0) or as a scrolling "run view".
//
//   hex7_dec (also in this file) is the 0-F seven-segment decoder, one
//   instance per display.
//
// Ports (hex_scroll_ctrl)
//   CLOCK_50   in   1   system clock, all state on the rising edge
//   KEY[0]     in       asynchronous active-low reset
//   KEY[1]     in       active-low push button (synchronised + debounced)
//   SW[3:0]    in       nibble data, sampled on an accepted press
//   SW[8]      in       clear (level)
//   SW[9]      in       run   (level)
//   HEX0..HEX5 out  7   active-low segments, bit0=a .. bit6=g, HEX5 leftmost
//   LEDR[3:0]  out      entry count
//   LEDR[8]    out      in RUN
//   LEDR[9]    out      buffer full
// ---------------------------------------------------------------------------

// Seven-segment decoder: active-low segments, bit0=a .. bit6=g.
//   nib    in  4  hex digit
//   blank  in  1  force all segments off
//   seg    out 7  segment drive
module hex7_dec (
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave it unassigned (no latch).
        seg = 7'h7F;
        if (!blank) begin
            case (nib)
                4'h0: seg = 7'h40;
                4'h1: seg = 7'h79;
                4'h2: seg = 7'h24;
                4'h3: seg = 7'h30;
                4'h4: seg = 7'h19;
                4'h5: seg = 7'h12;
                4'h6: seg = 7'h02;
                4'h7: seg = 7'h78;
                4'h8: seg = 7'h00;
                4'h9: seg = 7'h10;
                4'hA: seg = 7'h08;
                4'hB: seg = 7'h03;
                4'hC: seg = 7'h46;
                4'hD: seg = 7'h21;
                4'hE: seg = 7'h06;
                4'hF: seg = 7'h0E;
                default: seg = 7'h7F;
            endcase
        end
    end
endmodule

module hex_scroll_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int STEP_HZ   = 2,
    parameter int DEPTH     = 8,        // legal 2..15
    parameter int DB_CYCLES = 250_000
) (
    input  logic       CLOCK_50,
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    logic clk;
    logic rst_n;
    assign clk   = CLOCK_50;
    assign rst_n = KEY[0];

    // SW[7:4] are not used by this block.
    logic sw_unused;
    assign sw_unused = ^SW[7:4];

    // -----------------------------------------------------------------------
    // Input synchronisers. The button path resets to the "pressed" level so
    // that a button held through reset release is not seen as a new press.
    // -----------------------------------------------------------------------
    logic key_m, key_s;
    logic clr_m, clear;
    logic run_m, run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_m <= 1'b0;
            key_s <= 1'b0;
            clr_m <= 1'b0;
            clear <= 1'b0;
            run_m <= 1'b0;
            run   <= 1'b0;
        end else begin
            key_m <= KEY[1];
            key_s <= key_m;
            clr_m <= SW[8];
            clear <= clr_m;
            run_m <= SW[9];
            run   <= run_m;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce: a new level is accepted on its DB_CYCLES-th consecutive
    // cycle; any return to the accepted level restarts the count.
    // -----------------------------------------------------------------------
    logic           db_level;
    logic [DBW-1:0] db_cnt;
    logic           db_hit;
    logic           push;

    assign db_hit = (key_s != db_level) && (db_cnt == DB_LAST);
    assign push   = db_hit && !key_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else if (key_s == db_level) begin
            db_cnt   <= '0;
        end else if (db_hit) begin
            db_level <= key_s;
            db_cnt   <= '0;
        end else begin
            db_cnt   <= db_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with count / offset / prescaler
    // -----------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [3:0]    count_q, count_d;
    logic [3:0]    offset_q, offset_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            offset_q <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            offset_q <= offset_d;
            presc_q  <= presc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        offset_d = offset_q;
        presc_d  = presc_q;
        wr_en    = push && (state_q != S_RUN) && !clear && (count_q < DEPTH_C);

        if (wr_en) begin
            count_d = count_q + 4'd1;
        end

        if (clear) begin
            state_d  = S_IDLE;
            count_d  = '0;
            offset_d = '0;
            presc_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wr_en) state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (run) begin
                        state_d  = S_RUN;
                        offset_d = '0;
                        presc_d  = '0;
                    end
                end
                S_RUN: begin
                    if (!run) begin
                        state_d  = S_LOAD;
                        offset_d = '0;
                        presc_d  = '0;
                    end else if (presc_q == PRE_LAST) begin
                        // Scroll step; offset wraps by compare, not modulo.
                        presc_d  = '0;
                        offset_d = (offset_q + 4'd1 == count_q) ? 4'd0 : offset_q + 4'd1;
                    end else begin
                        presc_d  = presc_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Nibble buffer. Sized to the full 4-bit index space so every index the
    // display logic forms is in range; entries at or above DEPTH are never
    // written.
    // -----------------------------------------------------------------------
    logic [3:0] nib_buf [0:15];

    // NOTE: storage arrays carry no reset; only entries below count are ever
    // shown, so their power-up contents never reach an output.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            nib_buf[count_q] <= SW[3:0];
        end
    end

    // -----------------------------------------------------------------------
    // Display selection (registered below)
    // -----------------------------------------------------------------------
    logic [5:0][3:0] nib_d;
    logic [5:0]      blank_d;
    logic [3:0]      ridx;
    logic [3:0]      lidx;

    always_comb begin
        nib_d   = '0;
        blank_d = '1;
        ridx    = offset_q;
        lidx    = '0;
        case (state_q)
            S_LOAD: begin
                // HEX0 is the newest entry; displays past count stay blank.
                for (int k = 0; k < 6; k++) begin
                    if (4'(k) < count_q) begin
                        lidx       = count_q - 4'd1 - 4'(k);
                        nib_d[k]   = nib_buf[lidx];
                        blank_d[k] = 1'b0;
                    end
                end
            end
            S_RUN: begin
                // NOTE: ridx is a running index reused across iterations,
                // which relies on blocking (=) update order inside this block.
                for (int i = 0; i < 6; i++) begin
                    nib_d[5-i]   = nib_buf[ridx];
                    blank_d[5-i] = 1'b0;
                    ridx         = (ridx + 4'd1 == count_q) ? 4'd0 : ridx + 4'd1;
                end
            end
            default: ;
        endcase
    end

    logic [5:0][3:0] nib_q;
    logic [5:0]      blank_q;
    logic [9:0]      led_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_q   <= '0;
            blank_q <= '1;
            led_q   <= '0;
        end else begin
            nib_q   <= nib_d;
            blank_q <= blank_d;
            led_q   <= {count_q == DEPTH_C, state_q == S_RUN, 4'b0000, count_q};
        end
    end

    logic [5:0][6:0] seg;

    for (genvar g = 0; g < 6; g++) begin : g_dec
        hex7_dec u_dec (
            .nib   (nib_q[g]),
            .blank (blank_q[g]),
            .seg   (seg[g])
        );
    end

    assign HEX0 = seg[0];
    assign HEX1 = seg[1];
    assign HEX2 = seg[2];
    assign HEX3 = seg[3];
    assign HEX4 = seg[4];
    assign HEX5 = seg[5];
    assign LEDR = led_q;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hex_scroll_ctrl
//   Directed bench for hex_scroll_ctrl with a small clock (CLK_HZ=8,
//   STEP_HZ=1 -> one scroll step every 8 cycles) and DB_CYCLES=2.
//   Expected display/LED states are queued as each stimulus is applied and
//   popped and compared once the DUT has had time to respond.
// ---------------------------------------------------------------------------
module tb_hex_scroll_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] KEY;
    logic [9:0] SW;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    hex_scroll_ctrl #(
        .CLK_HZ    (8),
        .STEP_HZ   (1),
        .DEPTH     (8),
        .DB_CYCLES (2)
    ) dut (
        .CLOCK_50 (clk),
        .KEY      (KEY),
        .SW       (SW),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .LEDR     (LEDR)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [41:0] hex;   // {HEX5..HEX0}
        logic [9:0]  led;
    } exp_t;

    exp_t sb[$];

    localparam logic [4:0] BL = 5'h10;   // blank display

    function automatic logic [6:0] seg(input logic [4:0] d);
        case (d)
            5'h00: seg = 7'h40;
            5'h01: seg = 7'h79;
            5'h02: seg = 7'h24;
            5'h03: seg = 7'h30;
            5'h04: seg = 7'h19;
            5'h05: seg = 7'h12;
            5'h06: seg = 7'h02;
            5'h07: seg = 7'h78;
            5'h08: seg = 7'h00;
            5'h09: seg = 7'h10;
            5'h0A: seg = 7'h08;
            5'h0B: seg = 7'h03;
            5'h0C: seg = 7'h46;
            5'h0D: seg = 7'h21;
            5'h0E: seg = 7'h06;
            5'h0F: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    endfunction

    task automatic expect_disp(input string tag,
                               input logic [4:0] d5, input logic [4:0] d4,
                               input logic [4:0] d3, input logic [4:0] d2,
                               input logic [4:0] d1, input logic [4:0] d0,
                               input logic [9:0] led);
        exp_t e;
        e.tag = tag;
        e.hex = {seg(d5), seg(d4), seg(d3), seg(d2), seg(d1), seg(d0)};
        e.led = led;
        sb.push_back(e);
    endtask

    task automatic drain();
        logic [41:0] obs;
        while (sb.size() > 0) begin
            exp_t e;
            e   = sb.pop_front();
            obs = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
            checks++;
            assert (obs === e.hex) else begin
                errors++;
                $error("FAIL %s hex: observed=%h expected=%h", e.tag, obs, e.hex);
            end
            checks++;
            assert (LEDR === e.led) else begin
                errors++;
                $error("FAIL %s ledr: observed=%h expected=%h", e.tag, LEDR, e.led);
            end
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: held low well past synchroniser + debounce, then released.
    task automatic press(input logic [3:0] v);
        SW[3:0] = v;
        KEY[1]  = 1'b0;
        wait_n(6);
        KEY[1]  = 1'b1;
        wait_n(6);
    endtask

    task automatic do_clear(input string tag);
        SW[8] = 1'b1;
        wait_n(5);
        expect_disp(tag, BL, BL, BL, BL, BL, BL, 10'h000);
        drain();
        SW[8] = 1'b0;
        wait_n(3);
    endtask

    initial begin
        KEY = 2'b10;
        SW  = '0;

        // Reset state
        wait_n(3);
        expect_disp("reset", BL, BL, BL, BL, BL, BL, 10'h000);
        drain();
        KEY[0] = 1'b1;
        wait_n(6);

        // 1: push 1,2,3 in load view
        press(4'h1);
        press(4'h2);
        press(4'h3);
        expect_disp("load_123", BL, BL, BL, 5'h1, 5'h2, 5'h3, 10'h003);
        drain();

        // 2: fill to DEPTH, ninth push dropped
        do_clear("clear_1");
        for (int v = 0; v < 8; v++) press(4'(v));
        expect_disp("full_8", 5'h2, 5'h3, 5'h4, 5'h5, 5'h6, 5'h7, 10'h208);
        drain();
        press(4'hF);
        expect_disp("ninth_drop", 5'h2, 5'h3, 5'h4, 5'h5, 5'h6, 5'h7, 10'h208);
        drain();

        // 3: run view with 8 entries
        SW[9] = 1'b1;
        wait_n(4);
        expect_disp("run_off0", 5'h0, 5'h1, 5'h2, 5'h3, 5'h4, 5'h5, 10'h308);
        drain();
        wait_n(7);
        expect_disp("run_pre_step", 5'h0, 5'h1, 5'h2, 5'h3, 5'h4, 5'h5, 10'h308);
        drain();
        wait_n(1);
        expect_disp("run_off1", 5'h1, 5'h2, 5'h3, 5'h4, 5'h5, 5'h6, 10'h308);
        drain();
        // 5b: a press in RUN is dropped
        press(4'hC);
        expect_disp("run_push_drop", 5'h2, 5'h3, 5'h4, 5'h5, 5'h6, 5'h7, 10'h308);
        drain();
        wait_n(43);
        expect_disp("run_off7", 5'h7, 5'h0, 5'h1, 5'h2, 5'h3, 5'h4, 10'h308);
        drain();
        wait_n(1);
        expect_disp("run_wrap", 5'h0, 5'h1, 5'h2, 5'h3, 5'h4, 5'h5, 10'h308);
        drain();

        // 4: two entries repeat across the displays; 5a: glitch ignored
        SW[9] = 1'b0;
        do_clear("clear_2");
        press(4'hA);
        press(4'hF);
        KEY[1] = 1'b0;
        wait_n(1);
        KEY[1] = 1'b1;
        wait_n(6);
        expect_disp("glitch", BL, BL, BL, BL, 5'hA, 5'hF, 10'h002);
        drain();
        SW[9] = 1'b1;
        wait_n(4);
        expect_disp("af_off0", 5'hA, 5'hF, 5'hA, 5'hF, 5'hA, 5'hF, 10'h102);
        drain();
        wait_n(8);
        expect_disp("af_off1", 5'hF, 5'hA, 5'hF, 5'hA, 5'hF, 5'hA, 10'h102);
        drain();

        // 6a: clear mid-RUN
        do_clear("clear_run");
        SW[9] = 1'b0;
        wait_n(3);

        // 6b: asynchronous reset mid-step, button held through release
        press(4'h5);
        SW[9] = 1'b1;
        wait_n(6);
        @(posedge clk);
        #2;
        KEY = 2'b00;
        #1;
        expect_disp("async_reset", BL, BL, BL, BL, BL, BL, 10'h000);
        drain();
        wait_n(3);
        SW[9]  = 1'b0;
        KEY[0] = 1'b1;
        wait_n(10);
        expect_disp("held_key_release", BL, BL, BL, BL, BL, BL, 10'h000);
        drain();
        KEY[1] = 1'b1;
        wait_n(6);
        expect_disp("key_up_no_push", BL, BL, BL, BL, BL, BL, 10'h000);
        drain();
        press(4'h3);
        expect_disp("post_reset_push", BL, BL, BL, BL, BL, 5'h3, 10'h001);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
